cpu_bus_ic: RTL

Parametrised CPU bus interconnect that replaces hand-written strobe/wait/read-mux logic in the aq32 top level. It decodes one CPU master port onto NUM_SLAVES slave ports using base/mask windows. Per slave, it generates either a fixed-latency read wait or passes the slave's own wait through. It adds bus-error reporting for unmapped addresses and a watchdog timeout for stalled slaves.

---
 rtl/aq32_bus_pkg.sv | 28 ++
 rtl/cpu_bus_decode.sv | 33 +++
 rtl/cpu_bus_ic.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/aq32_bus_pkg.sv
// Shared definitions for the aq32 CPU bus: FSM states, the slave latency code
// and the memory map used to build the interconnect windows.
package aq32_bus_pkg;

  localparam logic [1:0] LAT_SLAVE_WAIT = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LAT   = 2'd1,
    SWAIT = 2'd2
  } state_t;

  localparam logic [31:0] SRAM_BASE     = 32'h0010_0000;
  localparam logic [31:0] SRAM_MASK     = 32'hFFF0_0000;
  localparam logic [31:0] TRAM_BASE     = 32'hFF00_0000;
  localparam logic [31:0] TRAM_MASK     = 32'hFFFF_F000;
  localparam logic [31:0] CHRAM_BASE    = 32'hFF10_0000;
  localparam logic [31:0] CHRAM_MASK    = 32'hFFFF_F800;
  localparam logic [31:0] VRAM_BASE     = 32'hFF20_0000;
  localparam logic [31:0] VRAM_MASK     = 32'hFFFF_C000;
  localparam logic [31:0] IO_VIDEO_BASE = 32'hFF30_0000;
  localparam logic [31:0] IO_VIDEO_MASK = 32'hFFFF_FF00;
  localparam logic [31:0] PAL_BASE      = 32'hFF40_0000;
  localparam logic [31:0] PAL_MASK      = 32'hFFFF_FF80;
  localparam logic [31:0] BOOTROM_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] BOOTROM_MASK  = 32'hFFFF_F000;

endpackage

// File: rtl/cpu_bus_decode.sv
// Priority base/mask address decoder: the lowest matching slave index wins.
module cpu_bus_decode #(
  parameter int                         NUM_SLAVES = 8,
  parameter int                         ADDR_W     = 32,
  parameter int                         SEL_W      = 3,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic [SEL_W-1:0]      sel,
  output logic                  no_hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]));
    end
  end

  // Walk downward so the lowest hitting index is the last one assigned.
  always_comb begin
    sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) sel = SEL_W'(i);
    end
  end

  assign no_hit = ~|hit;

endmodule

// File: rtl/cpu_bus_ic.sv
// CPU bus interconnect: one master onto NUM_SLAVES windows with fixed or
// slave-driven wait, unmapped/timeout bus errors and sticky error capture.
module cpu_bus_ic
  import aq32_bus_pkg::*;
#(
  parameter int                           NUM_SLAVES     = 8,
  parameter int                           ADDR_W         = 32,
  parameter int                           DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE       = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK       = '0,
  parameter logic [NUM_SLAVES*2-1:0]      SLV_LAT        = '0,
  parameter int                           TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wrdata,
  input  logic [DATA_W/8-1:0]          m_bytesel,
  input  logic                         m_wren,
  input  logic                         m_strobe,
  output logic                         m_wait,
  output logic [DATA_W-1:0]            m_rddata,
  output logic                         m_buserr,
  output logic [NUM_SLAVES-1:0]        s_strobe,
  input  logic [NUM_SLAVES-1:0]        s_wait,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rddata,
  output logic                         err_valid,
  output logic [ADDR_W-1:0]            err_addr,
  output logic                         err_timeout,
  input  logic                         err_clear,
  output state_t                       dbg_state
);

  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // Master handshake: a transfer completes in any cycle with m_strobe high and
  // m_wait low; the following cycle is always cycle 0 of a new transaction.

  state_t                  state;
  logic [1:0]              cnt;
  logic [TCNT_W-1:0]       tcnt;
  logic [NUM_SLAVES-1:0]   hit;
  logic [SEL_W-1:0]        sel;
  logic                    no_hit;
  logic [1:0]              sel_lat;
  logic                    sel_wait;
  logic [DATA_W-1:0]       sel_rd;
  logic                    unmapped;
  logic                    timeout;
  logic                    unused_inputs;

  assign unused_inputs = ^{m_wrdata, m_bytesel};
  assign dbg_state     = state;

  cpu_bus_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .addr   (m_addr),
    .hit    (hit),
    .sel    (sel),
    .no_hit (no_hit)
  );

  always_comb begin
    sel_lat  = '0;
    sel_wait = 1'b0;
    sel_rd   = '0;
    s_strobe = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_lat     = SLV_LAT[i*2 +: 2];
        sel_wait    = s_wait[i];
        sel_rd      = s_rddata[i*DATA_W +: DATA_W];
        s_strobe[i] = m_strobe && !no_hit;
      end
    end
  end

  assign unmapped = (state == IDLE) && m_strobe && no_hit;
  assign timeout  = (state == SWAIT) && m_strobe && (tcnt == TCNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    m_wait = 1'b0;
    case (state)
      IDLE: begin
        if (m_strobe && !no_hit) begin
          if (sel_lat != LAT_SLAVE_WAIT) m_wait = !m_wren;
          else                           m_wait = sel_wait;
        end
      end
      LAT:     m_wait = m_strobe && (cnt != 2'd0);
      SWAIT:   m_wait = m_strobe && !timeout && sel_wait;
      default: m_wait = 1'b0;
    endcase
  end

  assign m_buserr = unmapped || timeout;
  assign m_rddata = timeout ? {DATA_W{1'b1}} : (no_hit ? '0 : sel_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_strobe && !no_hit && m_wait) begin
            if (sel_lat != LAT_SLAVE_WAIT) begin
              state <= LAT;
              cnt   <= sel_lat - 2'd1;
            end else begin
              state <= SWAIT;
              tcnt  <= TCNT_W'(1);
            end
          end
        end
        LAT: begin
          if (!m_strobe || !m_wait) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        SWAIT: begin
          // tcnt stops at TIMEOUT_CYCLES because that cycle always completes.
          if (!m_strobe || !m_wait) begin
            state <= IDLE;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_valid   <= 1'b0;
      err_addr    <= '0;
      err_timeout <= 1'b0;
    end else if (m_buserr && (!err_valid || err_clear)) begin
      err_valid   <= 1'b1;
      err_addr    <= m_addr;
      err_timeout <= timeout;
    end else if (err_clear) begin
      err_valid <= 1'b0;
    end
  end

endmodule
